// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: PC/IR ownership, next-PC select and a one-word
// prefetch buffer fed by a variable-latency req/ack instruction memory.
module ifu_prefetch #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcwr,
  input  logic              irwr,
  input  logic [1:0]        npcop,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       link_addr,
  output logic [31:0]       ir,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [25:0]       imm26,
  output logic              stall,
  output logic              misalign
);

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_VALID   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] stale_q;
  logic [31:0]       ir_q;
  logic [31:0]       buf_q;

  logic              hit;
  logic              pc_we;
  logic              ir_we;
  logic              buf_we;
  logic              stale_we;
  logic [31:0]       word;
  logic [ADDR_W-1:0] npc;

  // Hit/stall: a word is available either from the buffer or forwarded from
  // the memory on the ack cycle of a live (non-stale) fetch.
  always_comb begin
    hit   = (state_q == ST_VALID) | ((state_q == ST_FETCH) & imem_ack);
    word  = (state_q == ST_VALID) ? buf_q : imem_rdata;
    stall = irwr & ~hit;
    pc_we = pcwr & ~stall;
    ir_we = irwr & hit;
  end

  always_comb begin
    npc = pc_q + ADDR_W'(4);
    unique case (npcop)
      2'b00: npc = pc_q + ADDR_W'(4);
      2'b01: npc = pc_q + {{(ADDR_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};
      2'b10: npc = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
      2'b11: npc = {rs_data[ADDR_W-1:2], 2'b00};
      default: npc = pc_q + ADDR_W'(4);
    endcase
  end

  // Gated by rst so the pulse stays low while reset is asserted.
  assign misalign = rst & pc_we & (npcop == 2'b11) & (rs_data[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    buf_we   = 1'b0;
    stale_we = 1'b0;
    unique case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        if (pc_we) begin
          // Without the ack the request is still in flight for the old pc:
          // remember its address and wait it out.
          state_d  = imem_ack ? ST_FETCH : ST_DISCARD;
          stale_we = ~imem_ack;
        end else if (imem_ack) begin
          state_d = ST_VALID;
          buf_we  = 1'b1;
        end
      end
      ST_VALID: begin
        if (pc_we) state_d = ST_FETCH;
      end
      ST_DISCARD: begin
        if (!pc_we && imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      buf_q   <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we)    pc_q    <= npc;
      if (ir_we)    ir_q    <= word;
      if (buf_we)   buf_q   <= imem_rdata;
      if (stale_we) stale_q <= pc_q;
    end
  end

  assign imem_req  = (state_q == ST_FETCH) | (state_q == ST_DISCARD);
  assign imem_addr = (state_q == ST_DISCARD) ? stale_q : pc_q;

  assign pc        = pc_q;
  assign link_addr = 32'(pc_q);
  assign ir        = ir_q;
  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm16     = ir_q[15:0];
  assign imm26     = ir_q[25:0];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios with literal expectations, then
// randomized controller/memory traffic checked against a transaction-level model.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcwr = 1'b0, irwr = 1'b0;
  logic [1:0]  npcop = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr, pc, link_addr, ir;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        stall, misalign;

  ifu_prefetch dut (
    .clk(clk), .rst(rst), .pcwr(pcwr), .irwr(irwr), .npcop(npcop),
    .rs_data(rs_data), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .link_addr(link_addr),
    .ir(ir), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .imm26(imm26), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory: one request at a time, ack after a chosen number of extra cycles.
  bit          busy = 0, rand_mode = 0, spur_en = 0;
  int          cnt = 0, next_lat = 0;
  logic [31:0] mem_word = '0;

  // Model: what the unit "knows" -- pc, ir, whether it already holds the word
  // for pc, and whether a request for an abandoned address is still in flight.
  bit          m_started, m_have, m_stale;
  logic [31:0] m_pc, m_ir, m_word, m_saddr;
  bit          e_pw, e_iw;
  logic [31:0] e_npc, e_wordv;

  task automatic model_reset();
    m_started = 0; m_have = 0; m_stale = 0;
    m_pc = 32'h0000_3000; m_ir = '0; m_word = '0; m_saddr = '0;
  endtask

  function automatic logic [31:0] calc_npc(logic [1:0] op, logic [31:0] p, logic [31:0] instr,
                                           logic [31:0] r);
    logic [31:0] off;
    off = {{16{instr[15]}}, instr[15:0]};
    case (op)
      2'b00:   return p + 32'd4;
      2'b01:   return p + off * 32'd4;
      2'b10:   return (p & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic step_pre();
    bit          e_req, e_hit, e_stall, e_mis;
    logic [31:0] e_addr;
    if (imem_req && !busy) begin
      busy = 1;
      cnt  = rand_mode ? $urandom_range(3) : next_lat;
      if (rand_mode) mem_word = $urandom;
    end
    if (busy && cnt == 0) begin
      imem_ack = 1'b1; imem_rdata = mem_word;
    end else if (!imem_req && spur_en && $urandom_range(7) == 0) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom;
    end
    #1;
    e_req   = m_started && (m_stale || !m_have);
    e_addr  = m_stale ? m_saddr : m_pc;
    e_hit   = m_started && (m_have || (!m_stale && imem_ack));
    e_wordv = m_have ? m_word : imem_rdata;
    e_stall = irwr && !e_hit;
    e_pw    = pcwr && !e_stall;
    e_iw    = irwr && e_hit;
    e_npc   = calc_npc(npcop, m_pc, m_ir, rs_data);
    e_mis   = e_pw && npcop == 2'b11 && rs_data[1:0] != 2'b00;
    if (rst) begin
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, e_addr);
      chk("stall", stall, e_stall);
      chk("misalign", misalign, e_mis);
      chk("pc", pc, m_pc);
      chk("link_addr", link_addr, m_pc);
      chk("ir", ir, m_ir);
      chk("fields", {opcode, funct, rs, rt, rd}, {5'd0, m_ir[31:26], m_ir[5:0], m_ir[25:21],
          m_ir[20:16], m_ir[15:11]});
      chk("imm", {imm16, imm26[25:16]}, {m_ir[15:0], m_ir[25:16]});
    end
  endtask

  task automatic step_post();
    logic [31:0] old_pc;
    @(posedge clk);
    old_pc = m_pc;
    if (rst) begin
      if (e_iw) m_ir = e_wordv;
      if (!m_started) begin
        m_started = 1;
        if (e_pw) m_pc = e_npc;
      end else if (e_pw) begin
        m_pc = e_npc;
        if (!m_stale && !m_have && !imem_ack) begin
          m_stale = 1; m_saddr = old_pc;
        end
        m_have = 0;
      end else if (m_stale) begin
        if (imem_ack) m_stale = 0;
      end else if (!m_have && imem_ack) begin
        m_have = 1; m_word = imem_rdata;
      end
    end
    if (busy) begin
      if (cnt == 0) busy = 0;
      else cnt--;
    end
    @(negedge clk);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic drive(input bit p, input bit i, input logic [1:0] op, input logic [31:0] r);
    pcwr = p; irwr = i; npcop = op; rs_data = r;
  endtask

  initial begin
    int  nstall;
    bit  got;
    logic [31:0] w1, w2, wj;
    w1 = 32'h2408_0005;
    w2 = 32'h1000_FFFE;
    wj = 32'h0800_0C10;
    model_reset();

    // Reset: outputs at reset values even with a misaligned jr requested.
    drive(1, 0, 2'b11, 32'h0000_0003);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // START then FETCH at 0x3000 with a same-cycle ack.
    drive(0, 0, 2'b00, 0);
    step_pre();
    chk("start_no_req", {31'd0, imem_req}, 32'd0);
    step_post();
    next_lat = 0; mem_word = w1;
    drive(1, 1, 2'b00, 0);
    step_pre();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    chk("first_stall", {31'd0, stall}, 32'd0);
    step_post();
    chk("first_ir", ir, w1);
    chk("first_pc", pc, 32'h0000_3004);

    // Latency 3 with irwr held: exactly three stall cycles.
    next_lat = 3; mem_word = w2; nstall = 0; got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step_pre();
      if (stall) nstall++;
      got = imem_ack;
      step_post();
    end
    chk("lat3_ack_seen", {31'd0, got}, 32'd1);
    chk("lat3_stalls", nstall, 32'd3);
    chk("lat3_ir", ir, w2);
    chk("lat3_pc", pc, 32'h0000_3008);

    // beq back by 2 words while the 0x3008 prefetch is outstanding.
    next_lat = 4;
    drive(1, 0, 2'b01, 0);
    step();
    chk("beq_pc", pc, 32'h0000_3000);
    drive(0, 0, 2'b00, 0);
    step_pre();
    chk("discard_req", {31'd0, imem_req}, 32'd1);
    chk("discard_addr", imem_addr, 32'h0000_3008);
    step_post();
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step_pre();
      got = imem_ack;
      step_post();
    end
    chk("discard_ack_seen", {31'd0, got}, 32'd1);
    next_lat = 0; mem_word = wj;
    drive(1, 1, 2'b00, 0);
    step_pre();
    chk("refetch_addr", imem_addr, 32'h0000_3000);
    chk("refetch_stall", {31'd0, stall}, 32'd0);
    step_post();
    chk("j_ir", ir, wj);

    // j, then misaligned jr.
    drive(1, 0, 2'b10, 0);
    step();
    chk("j_pc", pc, 32'h0000_3040);
    drive(1, 0, 2'b11, 32'h0000_3055);
    step_pre();
    chk("jr_misalign", {31'd0, misalign}, 32'd1);
    step_post();
    chk("jr_pc", pc, 32'h0000_3054);
    drive(0, 0, 2'b00, 0);
    step_pre();
    chk("jr_misalign_gone", {31'd0, misalign}, 32'd0);
    step_post();

    // Wrap at the top of the address space.
    drive(1, 0, 2'b11, 32'hFFFF_FFFC);
    step();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    drive(1, 0, 2'b00, 0);
    step();
    chk("wrap_pc", pc, 32'h0);
    drive(0, 0, 2'b00, 0);
    step_pre();
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0);
    step_post();

    // Reset in the middle of an outstanding request.
    next_lat = 5;
    drive(1, 1, 2'b00, 0);
    mem_word = w1;
    step();
    drive(0, 0, 2'b00, 0);
    step();
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0000_3000);
    chk("midrst_ir", ir, 32'h0);
    @(negedge clk);
    busy = 0; imem_ack = 1'b0;
    model_reset();
    rst = 1'b1;
    step_pre();
    chk("restart_start", {31'd0, imem_req}, 32'd0);
    step_post();
    next_lat = 1;
    step_pre();
    chk("restart_addr", imem_addr, 32'h0000_3000);
    step_post();

    // Randomized traffic with spurious acks and occasional resets.
    rand_mode = 1; spur_en = 1;
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(7) != 0) r[1:0] = 2'b00;
      drive($urandom_range(2) != 0, $urandom_range(1) != 0, 2'($urandom_range(3)), r);
      if (k % 700 == 699) begin
        rst = 1'b0;
        @(negedge clk);
        busy = 0; imem_ack = 1'b0;
        model_reset();
        rst = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch unit for the multi-cycle MIPS core. It owns PC, IR and next-PC selection, and supplies opcode/funct and the instruction fields to the controller.
- It consumes the controller's pcwr, irwr and npcop.
- It prefetches the word at the current PC from a variable-latency instruction memory over a req/ack handshake.
- It raises stall when the controller asks for an instruction that has not yet arrived.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and instruction memory address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pcwr  in  1  PC write enable from the controller.
- irwr  in  1  IR write enable from the controller.
- npcop  in  2  next-PC select: 00 pc+4, 01 branch, 10 jump, 11 register.
- rs_data  in  32  GPR[rs] value, used by jr/jalr.
- imem_rdata  in  32  instruction word returned by memory; valid when imem_ack=1.
- imem_ack  in  1  one-cycle acknowledge for the outstanding request.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address (word aligned).
- pc  out  ADDR_W  current PC.
- link_addr  out  32  return address for jal/jalr; equals pc.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26].
- funct  out  6  ir[5:0].
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- imm16  out  16  ir[15:0].
- imm26  out  26  ir[25:0].
- stall  out  1  controller/datapath must hold its current state.
- misalign  out  1  one-cycle pulse when a register target has bits [1:0] != 00.

Behaviour:
- Reset values (rst=0, asynchronous): pc=RESET_PC, ir=0, buffer invalid, state=START, imem_req=0, misalign=0. While rst=0, imem_req=0 regardless of any in-flight memory transaction.
- States:
  - START: always goes to FETCH on the next cycle.
  - FETCH: imem_req=1, imem_addr=pc.
  - VALID: buffer holds the word for pc; imem_req=0.
  - DISCARD: imem_req=1, imem_addr held at the stale address.
- Handshake rules: once imem_req is raised, req and addr stay stable until imem_ack. Exactly one request is outstanding at a time. An imem_ack seen outside FETCH/DISCARD is ignored.
- hit = (state==VALID) | (state==FETCH & imem_ack). The instruction word is the buffer in VALID and imem_rdata (forwarded) in FETCH.
- stall = irwr & ~hit, combinational. While stall=1, both irwr and pcwr are ignored: PC and IR hold.
- irwr & hit: ir <= instruction word on the edge. The next instruction's fields appear one cycle after the irwr cycle.
- next-PC computation, where pc already holds instr_addr+4 because the fetch cycle writes pc+4:
  - 00: pc+4
  - 01: pc + (sign_extend(imm16) << 2), using the imm16 field of ir
  - 10: {pc[31:28], imm26, 2'b00}
  - 11: {rs_data[31:2], 2'b00}. If rs_data[1:0] != 0, misalign pulses in the same cycle as the PC write.
- Effective pcwr (pcwr & ~stall) sets pc <= npc and invalidates the buffer. Next state:
  - from VALID: FETCH
  - from FETCH with imem_ack the same cycle: FETCH; the returned data is consumed only if irwr is also set, otherwise dropped
  - from FETCH without ack: DISCARD
  - from DISCARD: stays DISCARD
- State transitions without pcwr:
  - FETCH, ack, no irwr: VALID, buffer <= imem_rdata.
  - FETCH, ack, irwr: the IR takes the word. The buffer still holds it for pc, so the state is VALID unless pcwr also fires.
  - DISCARD, ack: data dropped, next state FETCH at the current pc.
- Simultaneous irwr and pcwr (normal fetch cycle): ir <= word at old pc, pc <= old pc+4, next state FETCH for the new pc.
- Arithmetic: all PC arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is silent. pc[1:0] is always 00.

Test Plan:
- Reset release, memory with 0-cycle-late ack → imem_req=1 with addr 0x3000 one cycle after START. irwr+pcwr on the ack cycle gives ir=imem_rdata, pc=0x3004, stall=0.
- Memory latency 3 cycles, irwr held from the first FETCH cycle → stall=1 for exactly 3 cycles, then ir loads and pc=0x3004.
- beq with ir imm16=16'hFFFE, pc=0x3008, npcop=01, pcwr while a prefetch is outstanding → pc=0x3000, state DISCARD. The stale ack is dropped and the next req goes to 0x3000.
- j with imm26=26'h0000C10, pc=0x3010 → pc=0x0000_3040. jr with rs_data=0x0000_3055 → pc=0x3054, misalign=1 for one cycle.
- Reset asserted (rst=0) while imem_req=1 → imem_req drops immediately, pc=0x3000, ir=0. After release, the fetch restarts at 0x3000.
- pc=32'hFFFF_FFFC, npcop=00, pcwr → pc=0, fetch to address 0.
